// File: rtl/nx_mimosa_tgt_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nx_mimosa_tgt_scheduler                                                  |
// | Round-robin sequencer of the shared IMM core and RTS smoother per target |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module nx_mimosa_tgt_scheduler #(
  parameter int N_TGT       = 8,
  parameter int TGT_W       = 3,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [N_TGT-1:0] tgt_mask,
  input  logic [N_TGT-1:0] meas_req,
  input  logic             clear_stats,
  output logic             imm_start,
  input  logic             imm_ready,
  input  logic             imm_done,
  output logic             rts_start,
  input  logic             rts_ready,
  input  logic             rts_done,
  output logic [TGT_W-1:0] cur_tgt,
  output logic             busy,
  output logic [N_TGT-1:0] pending,
  output logic [N_TGT-1:0] overrun,
  output logic             timeout_err,
  output logic [CNT_W-1:0] served_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_IMM_REQ  = 3'd1,
    ST_IMM_WAIT = 3'd2,
    ST_RTS_REQ  = 3'd3,
    ST_RTS_WAIT = 3'd4
  } state_t;

  state_t           r_state, w_next;
  logic [TGT_W-1:0] r_last_grant, r_cur_tgt, w_pick, w_idx;
  logic [TGT_W:0]   w_sum;
  logic [N_TGT-1:0] r_pending, r_overrun, w_eligible, w_grant_vec, w_pending_nxt;
  logic             w_found, w_grant, w_wd_expire, w_timeout, w_served, w_wait;
  logic [WD_W-1:0]  r_wd;
  logic             r_timeout_err;
  logic [CNT_W-1:0] r_served_cnt, r_timeout_cnt;

  assign w_eligible = r_pending & tgt_mask;

  // Search starts one past the last grant and wraps modulo N_TGT.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 1; k <= N_TGT; k++) begin
      w_sum = {1'b0, r_last_grant} + (TGT_W+1)'(k);
      if (w_sum >= (TGT_W+1)'(N_TGT)) w_sum = w_sum - (TGT_W+1)'(N_TGT);
      w_idx = w_sum[TGT_W-1:0];
      if (!w_found && w_eligible[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  assign w_grant     = (r_state == ST_IDLE) && enable && w_found;
  assign w_wd_expire = (r_wd == WD_W'(TIMEOUT_CYC - 1));
  assign w_wait      = (r_state == ST_IMM_WAIT) || (r_state == ST_RTS_WAIT);

  always_comb begin
    w_grant_vec = '0;
    if (w_grant) w_grant_vec[w_pick] = 1'b1;
    // A request coinciding with its own grant re-arms pending without overrun.
    w_pending_nxt = tgt_mask & (meas_req | (r_pending & ~w_grant_vec));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    imm_start = 1'b0;
    rts_start = 1'b0;
    w_timeout = 1'b0;
    w_served  = 1'b0;
    case (r_state)
      ST_IDLE:     if (w_grant) w_next = ST_IMM_REQ;
      ST_IMM_REQ: begin
        imm_start = 1'b1;
        if (imm_ready) w_next = ST_IMM_WAIT;
      end
      ST_IMM_WAIT: begin
        if (imm_done) begin
          w_next = ST_RTS_REQ;
        end else if (w_wd_expire) begin
          w_next    = ST_IDLE;
          w_timeout = 1'b1;
        end
      end
      ST_RTS_REQ: begin
        rts_start = 1'b1;
        if (rts_ready) w_next = ST_RTS_WAIT;
      end
      ST_RTS_WAIT: begin
        if (rts_done) begin
          w_next   = ST_IDLE;
          w_served = 1'b1;
        end else if (w_wd_expire) begin
          w_next    = ST_IDLE;
          w_timeout = 1'b1;
        end
      end
      default:     w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant  <= TGT_W'(N_TGT - 1);
      r_cur_tgt     <= '0;
      r_pending     <= '0;
      r_overrun     <= '0;
      r_wd          <= '0;
      r_timeout_err <= 1'b0;
      r_served_cnt  <= '0;
      r_timeout_cnt <= '0;
    end else begin
      r_pending     <= w_pending_nxt;
      r_timeout_err <= w_timeout;
      if (w_grant) begin
        r_last_grant <= w_pick;
        r_cur_tgt    <= w_pick;
      end
      if (r_state != w_next) r_wd <= '0;
      else if (w_wait)       r_wd <= r_wd + WD_W'(1);
      if (clear_stats) begin
        r_overrun     <= '0;
        r_served_cnt  <= '0;
        r_timeout_cnt <= '0;
      end else begin
        r_overrun <= r_overrun | (meas_req & r_pending & ~w_grant_vec);
        if (w_served && (r_served_cnt != '1))   r_served_cnt  <= r_served_cnt + CNT_W'(1);
        if (w_timeout && (r_timeout_cnt != '1)) r_timeout_cnt <= r_timeout_cnt + CNT_W'(1);
      end
    end
  end

  assign cur_tgt     = r_cur_tgt;
  assign busy        = (r_state != ST_IDLE);
  assign pending     = r_pending;
  assign overrun     = r_overrun;
  assign timeout_err = r_timeout_err;
  assign served_cnt  = r_served_cnt;
  assign timeout_cnt = r_timeout_cnt;

endmodule
`default_nettype wire

// File: tb/tb_nx_mimosa_tgt_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_nx_mimosa_tgt_scheduler                                               |
// | Directed self-checking bench for the target scheduler (TIMEOUT_CYC=16)   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_nx_mimosa_tgt_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] tgt_mask, meas_req;
  logic       clear_stats;
  logic       imm_start, imm_ready, imm_done;
  logic       rts_start, rts_ready, rts_done;
  logic [2:0] cur_tgt;
  logic       busy;
  logic [7:0] pending, overrun;
  logic       timeout_err;
  logic [15:0] served_cnt, timeout_cnt;

  int errors = 0;
  int checks = 0;
  int hi_cnt;

  nx_mimosa_tgt_scheduler #(
    .N_TGT(8), .TGT_W(3), .TIMEOUT_CYC(16), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .tgt_mask(tgt_mask),
    .meas_req(meas_req), .clear_stats(clear_stats),
    .imm_start(imm_start), .imm_ready(imm_ready), .imm_done(imm_done),
    .rts_start(rts_start), .rts_ready(rts_ready), .rts_done(rts_done),
    .cur_tgt(cur_tgt), .busy(busy), .pending(pending), .overrun(overrun),
    .timeout_err(timeout_err), .served_cnt(served_cnt), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Engine model: always ready, done 5 cycles after the accepted start.
  task automatic service(input logic [2:0] exp_tgt);
    int n = 0;
    while (!imm_start && n < 40) begin
      tick();
      n++;
    end
    chk("imm_start_seen", 32'(imm_start), 32'd1);
    chk("cur_tgt_imm", 32'(cur_tgt), 32'(exp_tgt));
    tick();
    chk("imm_start_drop", 32'(imm_start), 32'd0);
    repeat (4) tick();
    imm_done = 1'b1;
    tick();
    imm_done = 1'b0;
    chk("rts_start", 32'(rts_start), 32'd1);
    chk("cur_tgt_rts", 32'(cur_tgt), 32'(exp_tgt));
    tick();
    chk("rts_start_drop", 32'(rts_start), 32'd0);
    repeat (4) tick();
    rts_done = 1'b1;
    tick();
    rts_done = 1'b0;
    chk("busy_after_rts", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; tgt_mask = 8'h00; meas_req = 8'h00;
    clear_stats = 1'b0; imm_ready = 1'b0; imm_done = 1'b0;
    rts_ready = 1'b0; rts_done = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_imm_start", 32'(imm_start), 32'd0);
    chk("rst_rts_start", 32'(rts_start), 32'd0);
    chk("rst_cur_tgt", 32'(cur_tgt), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_served", 32'(served_cnt), 32'd0);
    chk("rst_tocnt", 32'(timeout_cnt), 32'd0);
    chk("rst_toerr", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    tgt_mask = 8'hFF; enable = 1'b1; imm_ready = 1'b1; rts_ready = 1'b1;
    tick();

    // Single request for target 2: grant at N+1, imm_start at N+2.
    meas_req = 8'h04;
    tick();
    meas_req = 8'h00;
    chk("t1_pending", 32'(pending), 32'h04);
    chk("t1_no_start_yet", 32'(imm_start), 32'd0);
    tick();
    chk("t1_imm_start_lat", 32'(imm_start), 32'd1);
    chk("t1_cur_tgt", 32'(cur_tgt), 32'd2);
    chk("t1_pending_clr", 32'(pending), 32'h00);
    service(3'd2);
    chk("t1_served", 32'(served_cnt), 32'd1);

    // Fresh reset so last_grant=7, then all eight targets at once.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    meas_req = 8'hFF;
    tick();
    meas_req = 8'h00;
    chk("t2_pending_all", 32'(pending), 32'hFF);
    for (int i = 0; i < 8; i++) service(3'(i));
    chk("t2_pending_zero", 32'(pending), 32'h00);
    chk("t2_served", 32'(served_cnt), 32'd8);

    // Masked requests ignored; clearing the mask drops pending.
    tgt_mask = 8'h0F;
    meas_req = 8'hF0;
    tick();
    meas_req = 8'h00;
    chk("t3_masked_pending", 32'(pending), 32'h00);
    tick();
    chk("t3_no_grant", 32'(busy), 32'd0);
    enable = 1'b0;
    meas_req = 8'h03;
    tick();
    meas_req = 8'h00;
    chk("t3_pending_03", 32'(pending), 32'h03);
    tgt_mask = 8'h00;
    tick();
    chk("t3_mask_clear", 32'(pending), 32'h00);
    tgt_mask = 8'hFF;

    // Overrun on a repeat request while pending and not granted.
    meas_req = 8'h20;
    tick();
    meas_req = 8'h00;
    chk("t4_pending_20", 32'(pending), 32'h20);
    chk("t4_no_overrun", 32'(overrun), 32'h00);
    meas_req = 8'h20;
    tick();
    meas_req = 8'h00;
    chk("t4_overrun", 32'(overrun), 32'h20);
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    chk("t4_overrun_clr", 32'(overrun), 32'h00);
    chk("t4_served_clr", 32'(served_cnt), 32'd0);

    // Request coinciding with grant of the same target: stays pending, no overrun.
    enable = 1'b1;
    meas_req = 8'h20;
    tick();
    meas_req = 8'h00;
    chk("t4_regrant_pending", 32'(pending), 32'h20);
    chk("t4_regrant_overrun", 32'(overrun), 32'h00);
    chk("t4_regrant_tgt", 32'(cur_tgt), 32'd5);
    service(3'd5);

    // Target 5 granted again in this IDLE cycle; its IMM never completes.
    meas_req = 8'h02;
    tick();
    meas_req = 8'h00;
    chk("t5_imm_start", 32'(imm_start), 32'd1);
    chk("t5_cur_tgt", 32'(cur_tgt), 32'd5);
    chk("t5_pending", 32'(pending), 32'h02);
    tick();
    repeat (15) tick();
    chk("t5_no_toerr_early", 32'(timeout_err), 32'd0);
    chk("t5_busy_waiting", 32'(busy), 32'd1);
    tick();
    chk("t5_toerr", 32'(timeout_err), 32'd1);
    chk("t5_tocnt", 32'(timeout_cnt), 32'd1);
    chk("t5_idle", 32'(busy), 32'd0);
    tick();
    chk("t5_toerr_pulse", 32'(timeout_err), 32'd0);
    chk("t5_next_tgt", 32'(cur_tgt), 32'd1);
    service(3'd1);
    chk("t5_served", 32'(served_cnt), 32'd2);

    // imm_ready low 7 cycles: imm_start held, single transfer.
    imm_ready = 1'b0;
    meas_req = 8'h08;
    tick();
    meas_req = 8'h00;
    tick();
    hi_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      if (imm_start) hi_cnt++;
      tick();
    end
    chk("t6_hold_cycles", 32'(hi_cnt), 32'd7);
    chk("t6_still_holding", 32'(imm_start), 32'd1);
    imm_ready = 1'b1;
    tick();
    chk("t6_single_xfer", 32'(imm_start), 32'd0);
    imm_done = 1'b1;
    tick();
    imm_done = 1'b0;
    chk("t6_rts_start", 32'(rts_start), 32'd1);
    tick();
    chk("t6_in_rts_wait", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_imm", 32'(imm_start), 32'd0);
    chk("t6_rst_rts", 32'(rts_start), 32'd0);
    chk("t6_rst_cur", 32'(cur_tgt), 32'd0);
    chk("t6_rst_served", 32'(served_cnt), 32'd0);
    chk("t6_rst_tocnt", 32'(timeout_cnt), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nx_mimosa_tgt_scheduler.md
Name: nx_mimosa_tgt_scheduler

Overview:
- Sequences the single shared 6-model IMM forward core and the fixed-lag RTS smoother across up to 8 tracked targets.
- Latches per-target measurement arrivals and picks the next target round-robin, filtered by the active-target mask.
- For each pick, runs an IMM update and then an RTS update for that target with valid/ready start handshakes and a done-wait watchdog.
- Keeps the runtime statistics that are exposed in the REG_STATS_BASE window.

Parameters:
N_TGT, 8, number of targets (MAX_TARGETS)
TGT_W, 3, target ID width ($clog2(N_TGT))
TIMEOUT_CYC, 4096, max cycles to wait for imm_done or rts_done
CNT_W, 16, statistics counter width

Ports:
clk  in  1  system clock, 250 MHz
rst  in  1  asynchronous active-high reset
enable  in  1  REG_CTRL[0]; 0 blocks new grants
tgt_mask  in  N_TGT  REG_TGT_MASK; 1 = target active
meas_req  in  N_TGT  one-cycle pulse per target: new measurement stored
clear_stats  in  1  pulse; clears counters and overrun
imm_start  out  1  IMM start request (valid)
imm_ready  in  1  IMM accepts start
imm_done  in  1  IMM finished current target (pulse)
rts_start  out  1  RTS start request (valid)
rts_ready  in  1  RTS accepts start
rts_done  in  1  RTS finished (pulse)
cur_tgt  out  TGT_W  target being serviced; drives both engines' tgt_id
busy  out  1  FSM not in IDLE
pending  out  N_TGT  latched request bits
overrun  out  N_TGT  sticky: request lost (meas_req while already pending)
timeout_err  out  1  one-cycle pulse when the watchdog fires
served_cnt  out  CNT_W  targets completed through RTS
timeout_cnt  out  CNT_W  watchdog events

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, all outputs 0, last_grant=N_TGT-1 so target 0 is first, watchdog=0.
- pending[i]:
  - Set on meas_req[i] & tgt_mask[i]; a masked request is ignored.
  - Cleared when tgt_mask[i]=0.
  - Cleared on the cycle target i is granted. If meas_req[i] arrives in that same cycle, pending[i] stays 1 and no overrun is flagged.
- overrun[i]: set when meas_req[i] & pending[i] & no grant of i in that cycle. Sticky until clear_stats.
- eligible = pending & tgt_mask. Round-robin search starts at last_grant+1 and wraps modulo N_TGT; the first set bit wins.
- FSM states:
  - IDLE: if enable & |eligible, latch cur_tgt and last_grant, clear pending[cur_tgt], go to IMM_REQ.
  - IMM_REQ: imm_start=1 and held until imm_ready. Transfer occurs on imm_start & imm_ready, then go to IMM_WAIT. imm_start drops the cycle after transfer.
  - IMM_WAIT: on imm_done go to RTS_REQ. If the watchdog reaches TIMEOUT_CYC-1, go to IDLE.
  - RTS_REQ: rts_start=1 held until rts_ready, then go to RTS_WAIT.
  - RTS_WAIT: on rts_done increment served_cnt and go to IDLE. Watchdog applies as in IMM_WAIT.
- Watchdog:
  - Cleared on entry to each WAIT state; counts cycles in that state.
  - On expiry: timeout_err pulses for 1 cycle, timeout_cnt increments, FSM returns to IDLE. The target is dropped (not re-queued).
  - done arriving on the expiry cycle takes priority; no timeout is recorded.
- Latency: meas_req at cycle N sets pending at N+1, IDLE grants at N+1, imm_start=1 at N+2 (with imm_ready=1, transfer at N+2).
- Minimum per-target turnaround is one IDLE cycle; back-to-back targets are not pipelined.
- enable deasserted mid-operation: the current target completes; no new grant is made. pending keeps accumulating.
- tgt_mask[cur_tgt] cleared mid-operation: the current operation completes.
- imm_done or rts_done outside its WAIT state is ignored.
- cur_tgt is stable from grant until the return to IDLE.
- Counters saturate at 2^CNT_W-1. clear_stats has priority over a same-cycle increment.
- rst asserted mid-operation: immediate return to reset state; imm_start and rts_start drop asynchronously.

Test Plan:
- tgt_mask=0xFF; single meas_req=0x04 at cycle 10; engines always ready with done 5 cycles after start -> imm_start high at cycle 12 with cur_tgt=2; rts_start follows; served_cnt=1; busy low after rts_done.
- meas_req=0xFF in one cycle; last_grant=7 -> service order 0,1,...,7; pending reaches 0; served_cnt=8.
- tgt_mask=0x0F, meas_req=0xF0 -> pending stays 0, no grant. Then mask=0x00 while pending=0x03 -> pending clears to 0.
- Repeat meas_req[5] while target 5 is pending and not granted -> overrun=0x20. Then clear_stats -> overrun=0.
- imm_done never arrives, TIMEOUT_CYC=16 -> timeout_err pulse exactly 16 cycles after entering IMM_WAIT; timeout_cnt=1; next eligible target granted.
- imm_ready held low 7 cycles -> imm_start held high 7 cycles, single transfer. Assert rst during RTS_WAIT -> all outputs 0 immediately.
